alu_cmd_sequencer: RTL

Upstream issue stage for the 8-bit `alu`. Buffers operand/opcode commands from a valid/ready producer in a small FIFO and drives `alu` inputs one command at a time. It then captures `ALU_Out`/`CarryOut` after the ALU's registered latency and returns a tagged result through a valid/ready response port. Illegal opcodes are trapped without touching the ALU, and divide-by-zero can optionally be trapped as well.

---
 rtl/alu_cmd_sequencer_pkg.sv | 36 +++
 rtl/alu_cmd_fifo.sv | 71 +++++++
 rtl/alu_cmd_sequencer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared types and constants for the ALU command sequencer: opcode
//   encodings, the divide-by-zero trap result, the buffered command record
//   and the sequencer FSM state type.
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_LAST = OP_DIV;

  localparam logic [7:0] DIV0_RESULT = 8'hFF;

  // One buffered command as accepted from the producer.
  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] tag;
  } alu_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } seq_state_t;

  // Opcodes beyond the last one the ALU implements are never issued.
  function automatic logic is_illegal_op(input logic [3:0] op);
    return op > OP_LAST;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// ---------------------------------------------------------------------------
// alu_cmd_fifo
//   Small synchronous FIFO of alu_cmd_t entries with a read/write pointer pair
//   and an occupancy count. Head entry is presented combinationally.
//
//   Parameters: DEPTH - number of entries (power of two, >= 2)
//   Ports:
//     clock, reset_n    - clock, asynchronous active-low reset
//     i_push, i_data    - write strobe and entry (ignored while full)
//     i_pop             - remove head (ignored while empty)
//     o_data            - current head entry
//     o_full, o_empty   - occupancy flags
// ---------------------------------------------------------------------------
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clock,
  input  logic     reset_n,
  input  logic     i_push,
  input  alu_cmd_t i_data,
  input  logic     i_pop,
  output alu_cmd_t o_data,
  output logic     o_full,
  output logic     o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  alu_cmd_t           r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W:0]     r_count;

  logic w_push;
  logic w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_data  = r_mem[r_rd_ptr];

  // NOTE: storage has no reset; only the pointers and count define validity,
  // so the array maps onto plain RAM/flops without a reset network.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// alu_cmd_sequencer
//   Issue stage for the 8-bit alu. Buffers commands in alu_cmd_fifo, drives
//   one command at a time onto the alu inputs, waits out the alu register
//   latency, then returns a tagged result on a valid/ready response port.
//   Illegal opcodes are answered with an error response without driving the
//   alu.
//
//   Build option: ALU_SEQ_DIV0_GUARD_EN - when defined, a divide by zero is
//   also trapped (rsp_data = 8'hFF, rsp_err = 1) instead of being issued.
//
//   Parameters: DEPTH (FIFO entries), ALU_LAT (alu input-to-output cycles)
//   Ports:
//     clock, reset_n                       - clock, async active-low reset
//     cmd_valid/cmd_ready, cmd_op/a/b/tag  - command channel
//     alu_a, alu_b, alu_sel                - registered alu operands/opcode
//     alu_out, alu_carry                   - alu result inputs
//     rsp_valid/rsp_ready, rsp_data/carry/err/tag - response channel
//     busy                                 - FIFO non-empty or FSM active
// ---------------------------------------------------------------------------
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic [3:0] cmd_tag,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_sel,
  input  logic [7:0] alu_out,
  input  logic       alu_carry,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_carry,
  output logic       rsp_err,
  output logic [3:0] rsp_tag,
  output logic       busy
);

  localparam int CNT_W = $clog2(ALU_LAT + 1) + 1;

  alu_cmd_t   w_cmd_in;
  alu_cmd_t   w_head;
  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_pop;
  logic       w_trap;
  logic [7:0] w_trap_data;

  seq_state_t        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_trap;
  logic [7:0]        r_trap_data;
  logic [3:0]        r_cur_tag;
  logic [7:0]        r_alu_a;
  logic [7:0]        r_alu_b;
  logic [3:0]        r_alu_sel;
  logic              r_rsp_valid;
  logic [7:0]        r_rsp_data;
  logic              r_rsp_carry;
  logic              r_rsp_err;
  logic [3:0]        r_rsp_tag;

  assign w_cmd_in = '{op: cmd_op, a: cmd_a, b: cmd_b, tag: cmd_tag};
  assign w_push   = cmd_valid && !w_full;

  // The head is taken when idle, or on the response handshake so a queued
  // command does not pay an extra IDLE cycle.
  assign w_pop = !w_empty &&
                 ((r_state == ST_IDLE) || ((r_state == ST_RESP) && rsp_ready));

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_data  (w_cmd_in),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    w_trap      = is_illegal_op(w_head.op);
    w_trap_data = 8'h00;
`ifdef ALU_SEQ_DIV0_GUARD_EN
    if ((w_head.op == OP_DIV) && (w_head.b == 8'd0)) begin
      w_trap      = 1'b1;
      w_trap_data = DIV0_RESULT;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_trap      <= 1'b0;
      r_trap_data <= '0;
      r_cur_tag   <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_sel   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_carry <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_tag   <= '0;
    end else begin
      case (r_state)
        ST_WAIT: begin
          if (r_cnt == '0) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_tag   <= r_cur_tag;
            if (r_trap) begin
              r_rsp_data  <= r_trap_data;
              r_rsp_carry <= 1'b0;
              r_rsp_err   <= 1'b1;
            end else begin
              r_rsp_data  <= alu_out;
              r_rsp_carry <= alu_carry;
              r_rsp_err   <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: ;
      endcase

      // A pop overrides the state update above. Legal commands wait ALU_LAT+1
      // cycles for the alu; trapped commands skip the alu and resolve on the
      // next edge, leaving the alu inputs untouched.
      if (w_pop) begin
        r_state     <= ST_WAIT;
        r_cur_tag   <= w_head.tag;
        r_trap      <= w_trap;
        r_trap_data <= w_trap_data;
        if (w_trap) begin
          r_cnt <= '0;
        end else begin
          r_cnt     <= CNT_W'(ALU_LAT);
          r_alu_a   <= w_head.a;
          r_alu_b   <= w_head.b;
          r_alu_sel <= w_head.op;
        end
      end
    end
  end

  assign cmd_ready = !w_full;
  assign busy      = !w_empty || (r_state != ST_IDLE);
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_sel   = r_alu_sel;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_carry = r_rsp_carry;
  assign rsp_err   = r_rsp_err;
  assign rsp_tag   = r_rsp_tag;

endmodule
